muldiv_unit: RTL and testbench

- Iterative HI/LO multiply/divide unit in the EX stage, beside the ALU, sharing the decoded instruction that drives ALU control selection.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, owns the architectural HI/LO registers, and services MTHI/MTLO writes.
- Raises `busy` so the hazard unit can stall the pipeline on MFHI/MFLO and any new mul/div until `done`.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_div_core.sv | 68 ++++++
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation
// encodings, FSM states, datapath widths and small decode helpers.
package muldiv_pkg;

  localparam int unsigned MD_XLEN = 32;
  localparam int unsigned MD_ITER = MD_XLEN;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } md_state_e;

  // MULT and DIV treat their operands as two's complement
  function automatic logic md_is_signed(input logic [1:0] op);
    return (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divide datapath: one quotient bit per step on unsigned operands.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture dividend/divisor and clear the partial remainder
//   step            perform one shift / trial-subtract iteration
//   dividend        unsigned dividend
//   divisor         unsigned divisor
//   quo_c, rem_c    quotient / remainder as they will be after this step
module muldiv_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_c,
  output logic [XLEN-1:0] rem_c
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // One restoring iteration; a borrow out of the trial subtract means keep the shifted value
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[XLEN]) begin
      rem_c = trial[XLEN-1:0];
      quo_c = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_c = shifted[XLEN-1:0];
      quo_c = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      rem_d = rem_c;
      quo_d = quo_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   src_a, src_b    rs / rt operands, sampled only at acceptance
//   flush           abort the in-flight operation
//   hi_we, lo_we    MTHI / MTLO write strobes, wdata is the write data
//   busy            operation in flight
//   done            one-cycle pulse, hi/lo hold the new result
//   hi, lo          architectural HI / LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN,
  parameter int unsigned ITER = MD_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_neg_q, res_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]  mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic            op_signed;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            accept;
  logic            div_load, div_step;
  logic [XLEN-1:0] div_quo_raw, div_rem_raw;
  logic [XLEN-1:0] div_quo, div_rem;
  logic [XLEN:0]   mul_sum;
  logic [PW-1:0]   prod_step;
  logic [PW-1:0]   mul_raw, mul_res;
  logic            mul_last;

  // Operand magnitudes: signed ops strip the sign, unsigned ops pass through
  always_comb begin
    op_signed = md_is_signed(op);
    a_abs = (op_signed && src_a[XLEN-1]) ? (~src_a + XLEN'(1)) : src_a;
    b_abs = (op_signed && src_b[XLEN-1]) ? (~src_b + XLEN'(1)) : src_b;
  end

  // Shift-add step: upper half accumulates, lower half shifts the multiplier out
  always_comb begin
    mul_sum   = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : XLEN'(0))};
    prod_step = {mul_sum, prod_q[XLEN-1:1]};
  end

`ifdef MULDIV_FAST_MUL_EN
  assign mul_raw  = PW'(mcand_q) * PW'(prod_q[XLEN-1:0]);
  assign mul_last = 1'b1;
`else
  assign mul_raw  = prod_step;
  assign mul_last = (cnt_q == '0);
`endif

  // Result sign fix-up applied on the final iteration
  always_comb begin
    mul_res = res_neg_q ? (~mul_raw + PW'(1)) : mul_raw;
    div_quo = res_neg_q ? (~div_quo_raw + XLEN'(1)) : div_quo_raw;
    div_rem = rem_neg_q ? (~div_rem_raw + XLEN'(1)) : div_rem_raw;
  end

  muldiv_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quo_c    (div_quo_raw),
    .rem_c    (div_rem_raw)
  );

  // Next-state, HI/LO update and operand capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
    accept    = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_MUL: begin
          prod_d = prod_step;
          if (mul_last) begin
            state_d = ST_FIN;
            hi_d    = mul_res[PW-1:XLEN];
            lo_d    = mul_res[XLEN-1:0];
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          div_step = 1'b1;
          if (cnt_q == '0) begin
            state_d = ST_FIN;
            hi_d    = div_rem;
            lo_d    = div_quo;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end

    // MTHI/MTLO only land while no iteration is running; in FIN they win over the result
    if ((state_q == ST_IDLE) || (state_q == ST_FIN)) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
      accept = start && !flush;
    end

    if (accept) begin
      cnt_d     = CNT_W'(ITER - 1);
      res_neg_d = op_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
      rem_neg_d = op_signed && src_a[XLEN-1];
      mcand_d   = a_abs;
      prod_d    = {XLEN'(0), b_abs};
      div_load  = md_is_div(op);
      state_d   = md_is_div(op) ? ST_DIV : ST_MUL;
    end

    busy_d = (state_d == ST_MUL) || (state_d == ST_DIV);
    done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with an expected-result queue.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = MD_ITER + 1;
`endif
  localparam int DIV_LAT = MD_ITER + 1;
  localparam int BOUND   = 200;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] sa, sb, p;
    logic [63:0] u;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin u = {32'd0, a} * {32'd0, b}; eh = u[63:32]; el = u[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin
          eh = a;
          el = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else begin
          p = sa / sb; el = p[31:0];
          p = sa % sb; eh = p[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin eh = a; el = 32'hFFFF_FFFF; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  // Drive one start cycle; returns in cycle T+1
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.lat = o[1] ? DIV_LAT : MUL_LAT;
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  // Wait for done (bounded), then compare latency and HI/LO against the queue head
  task automatic wait_done(input string tag, input int k0, output exp_t e);
    int k = k0;
    while (done !== 1'b1 && k < BOUND) begin
      tick();
      k++;
    end
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
      e.hi = 'x; e.lo = 'x; e.lat = -1;
    end else begin
      e = sb_q.pop_front();
    end
    chk({tag, "_lat"}, 64'(k), 64'(e.lat));
    chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
    chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    do_op(o, a, b, 1'b1, eh, el);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, 1, e);
    tick();
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk({tag, "_no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    exp_t e;
    logic [31:0] rh, rl, ra, rb;
    logic [1:0]  ro;

    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    run("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("div_neg7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("divu_by0", MD_DIVU, 32'h0000_0064, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run("div_by0_neg", MD_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'h0000_0001);

    for (int i = 0; i < 4; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      model(ro, ra, rb, rh, rl);
      run($sformatf("rand%0d", i), ro, ra, rb, rh, rl);
    end

    // Preload via MTHI/MTLO in IDLE
    hi_we = 1'b1; wdata = 32'h0000_1234; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0000_5678; tick();
    lo_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234);
    chk("mtlo", 64'(lo), 64'h5678);

    // Flush at T+10 together with an ignored start
    do_op(MD_DIVU, 32'd100, 32'd7, 1'b0, '0, '0);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1; start = 1'b1; op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
    tick();
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    quiet("flush", 40);
    chk("flush_busy_late", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h1234);
    chk("flush_lo", 64'(lo), 64'h5678);

    // Start while busy is ignored
    do_op(MD_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; op = MD_MULT; src_a = 32'd2; src_b = 32'd3;
    tick();
    start = 1'b0;
    wait_done("busy_ign", 6, e);
    quiet("busy_ign", 40);
    chk("busy_ign_sb", 64'(sb_q.size()), 64'd0);

    // Back-to-back: second start in the FIN cycle of the first
    do_op(MD_MULTU, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42);
    wait_done("b2b_first", 1, e);
    do_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_done("b2b_second", 1, e);

    // MTHI in FIN wins over the result; LO keeps the result
    hi_we = 1'b1; wdata = 32'h0000_CAFE; tick();
    hi_we = 1'b0;
    chk("fin_mthi_hi", 64'(hi), 64'hCAFE);
    chk("fin_mthi_lo", 64'(lo), 64'h0FFF_FFFF);
    chk("final_sb", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
